// File: rtl/univ_shift_reg_if.sv
// Bus bundle for univ_shift_reg: control/data inputs and register-state outputs.
// Optional macro SHIFT_ROTATE_EN adds the ROT control signal.
interface univ_shift_reg_if #(
    parameter int WIDTH = 8
);
    localparam int CW = $clog2(WIDTH + 1);

    logic             EN;
    logic [1:0]       MODE;
    logic             SIL;
    logic             SIR;
    logic [WIDTH-1:0] D;
`ifdef SHIFT_ROTATE_EN
    logic             ROT;
`endif
    logic [WIDTH-1:0] Q;
    logic             SOL;
    logic             SOR;
    logic [CW-1:0]    CNT;
    logic             DONE;

`ifdef SHIFT_ROTATE_EN
    modport master (output EN, MODE, SIL, SIR, D, ROT, input Q, SOL, SOR, CNT, DONE);
    modport slave  (input EN, MODE, SIL, SIR, D, ROT, output Q, SOL, SOR, CNT, DONE);
`else
    modport master (output EN, MODE, SIL, SIR, D, input Q, SOL, SOR, CNT, DONE);
    modport slave  (input EN, MODE, SIL, SIR, D, output Q, SOL, SOR, CNT, DONE);
`endif
endinterface

// File: rtl/univ_shift_reg.sv
// Universal shift register: hold, shift left, shift right, parallel load.
// A saturating shift counter with DONE lets a controller (de)serialise a
// full WIDTH-bit word without an external counter.
// Optional macro SHIFT_ROTATE_EN: ROT=1 turns shifts into rotates.
module univ_shift_reg #(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic           C,
    input  logic           CLR,
    univ_shift_reg_if.slave bus
);
    localparam int            CW      = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

    typedef enum logic [1:0] {
        MODE_HOLD  = 2'b00,
        MODE_SHL   = 2'b01,
        MODE_SHR   = 2'b10,
        MODE_LOAD  = 2'b11
    } mode_e;

    logic [WIDTH-1:0] r_q;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] w_q_next;
    logic [CW-1:0]    w_cnt_next;
    logic             w_fill_left;
    logic             w_fill_right;

    // Counter increment that sticks at WIDTH so DONE stays high on extra shifts.
    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
        return (c == CNT_MAX) ? c : c + CW'(1);
    endfunction

    // Select the bit entering each end: serial input, or the wrapped-around bit when rotating.
    always_comb begin
`ifdef SHIFT_ROTATE_EN
        w_fill_left  = bus.ROT ? r_q[WIDTH-1] : bus.SIL;
        w_fill_right = bus.ROT ? r_q[0]       : bus.SIR;
`else
        w_fill_left  = bus.SIL;
        w_fill_right = bus.SIR;
`endif
    end

    // Next-state for register and counter; EN low or hold mode keeps both.
    always_comb begin
        w_q_next   = r_q;
        w_cnt_next = r_cnt;
        if (bus.EN) begin
            case (mode_e'(bus.MODE))
                MODE_SHL: begin
                    w_q_next   = {r_q[WIDTH-2:0], w_fill_left};
                    w_cnt_next = sat_inc(r_cnt);
                end
                MODE_SHR: begin
                    w_q_next   = {w_fill_right, r_q[WIDTH-1:1]};
                    w_cnt_next = sat_inc(r_cnt);
                end
                MODE_LOAD: begin
                    w_q_next   = bus.D;
                    w_cnt_next = '0;
                end
                default: begin
                    w_q_next   = r_q;
                    w_cnt_next = r_cnt;
                end
            endcase
        end
    end

    // State register; CLR low overrides everything and aborts any operation.
    always_ff @(posedge C) begin
        if (!CLR) begin
            r_q   <= RST_VAL;
            r_cnt <= '0;
        end else begin
            r_q   <= w_q_next;
            r_cnt <= w_cnt_next;
        end
    end

    assign bus.Q    = r_q;
    assign bus.SOL  = r_q[WIDTH-1];
    assign bus.SOR  = r_q[0];
    assign bus.CNT  = r_cnt;
    assign bus.DONE = (r_cnt == CNT_MAX);
endmodule

// File: tb/tb_univ_shift_reg.sv
// Self-checking bench for univ_shift_reg (WIDTH=8, RST_VAL=0).
// Directed scenarios with literal expectations plus randomized traffic,
// all compared every cycle against an arithmetic reference model.
module tb_univ_shift_reg;
    localparam int W    = 8;
    localparam int MASK = (1 << W) - 1;
`ifdef SHIFT_ROTATE_EN
    localparam bit ROT_BUILD = 1'b1;
`else
    localparam bit ROT_BUILD = 1'b0;
`endif

    logic C   = 1'b0;
    logic CLR = 1'b0;

    univ_shift_reg_if #(.WIDTH(W)) bus ();

    univ_shift_reg #(.WIDTH(W), .RST_VAL(8'h00)) dut (
        .C   (C),
        .CLR (CLR),
        .bus (bus)
    );

    always #5 C = ~C;

    int n_tests = 0;
    int n_fail  = 0;
    int mq      = 0;   // model register contents
    int mc      = 0;   // model shift count
    bit chk_en  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Apply one cycle of inputs, then advance the model with the pre-edge values.
    task automatic step(input bit clr, input bit en, input bit [1:0] mode,
                        input bit sil, input bit sir, input bit [7:0] d, input bit rot);
        bit rotate;
        CLR      = clr;
        bus.EN   = en;
        bus.MODE = mode;
        bus.SIL  = sil;
        bus.SIR  = sir;
        bus.D    = d;
`ifdef SHIFT_ROTATE_EN
        bus.ROT  = rot;
`endif
        rotate = ROT_BUILD && rot;
        @(posedge C);
        if (!clr) begin
            mq = 0;
            mc = 0;
        end else if (en) begin
            case (mode)
                2'b01: begin
                    mq = ((mq << 1) | (rotate ? (mq >> (W - 1)) : int'(sil))) & MASK;
                    mc = (mc + 1 > W) ? W : mc + 1;
                end
                2'b10: begin
                    mq = (mq >> 1) | ((rotate ? (mq & 1) : int'(sir)) << (W - 1));
                    mc = (mc + 1 > W) ? W : mc + 1;
                end
                2'b11: begin
                    mq = int'(d);
                    mc = 0;
                end
                default: ;
            endcase
        end
        #1;
    endtask

    // Every cycle after reset, all outputs must match the model.
    always @(negedge C) begin
        if (chk_en) begin
            check("Q",    bus.Q,    mq);
            check("SOL",  bus.SOL,  (mq >> (W - 1)) & 1);
            check("SOR",  bus.SOR,  mq & 1);
            check("CNT",  bus.CNT,  mc);
            check("DONE", bus.DONE, (mc == W) ? 1 : 0);
        end
    end

    logic [7:0] exp_l [8] = '{8'h4A, 8'h94, 8'h28, 8'h50, 8'hA0, 8'h40, 8'h80, 8'h00};
    logic       exp_s [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [7:0] exp_r [8] = '{8'h80, 8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hFE, 8'hFF};

    initial begin
        bus.EN = 1'b0; bus.MODE = 2'b00; bus.SIL = 1'b0; bus.SIR = 1'b0; bus.D = '0;
`ifdef SHIFT_ROTATE_EN
        bus.ROT = 1'b0;
`endif
        // 1. reset with load request pending
        step(0, 1, 2'b11, 0, 0, 8'hA5, 0);
        chk_en = 1'b1;
        step(0, 1, 2'b11, 0, 0, 8'hA5, 0);
        check("rst_Q", bus.Q, 8'h00);
        check("rst_CNT", bus.CNT, 0);
        check("rst_DONE", bus.DONE, 0);
        check("rst_SOL", bus.SOL, 0);
        check("rst_SOR", bus.SOR, 0);

        // 2. left serialise
        step(1, 1, 2'b11, 0, 0, 8'hA5, 0);
        check("ld_Q", bus.Q, 8'hA5);
        for (int i = 0; i < 8; i++) begin
            check("ser_SOL_before", bus.SOL, exp_s[i]);
            step(1, 1, 2'b01, 0, 1, 8'hFF, 0);
            check("ser_Q", bus.Q, exp_l[i]);
            check("ser_CNT", bus.CNT, i + 1);
            check("ser_DONE", bus.DONE, (i == 7) ? 1 : 0);
        end
        step(1, 1, 2'b01, 0, 1, 8'hFF, 0);
        check("sat_CNT", bus.CNT, 8);
        check("sat_DONE", bus.DONE, 1);

        // 3. right deserialise then reload
        step(1, 1, 2'b11, 0, 0, 8'h00, 0);
        for (int i = 0; i < 8; i++) begin
            step(1, 1, 2'b10, 0, 1, 8'h55, 0);
            check("des_Q", bus.Q, exp_r[i]);
        end
        check("des_CNT", bus.CNT, 8);
        check("des_DONE", bus.DONE, 1);
        step(1, 1, 2'b11, 1, 1, 8'h3C, 0);
        check("rl_Q", bus.Q, 8'h3C);
        check("rl_CNT", bus.CNT, 0);
        check("rl_DONE", bus.DONE, 0);

        // 4. enable low and hold mode: reach Q=5A, CNT=3 first
        step(1, 1, 2'b11, 0, 0, 8'h0B, 0);
        step(1, 1, 2'b01, 0, 0, 8'h00, 0);
        step(1, 1, 2'b01, 1, 0, 8'h00, 0);
        step(1, 1, 2'b01, 0, 0, 8'h00, 0);
        check("pre_hold_Q", bus.Q, 8'h5A);
        check("pre_hold_CNT", bus.CNT, 3);
        for (int i = 0; i < 4; i++) begin
            step(1, 0, 2'b01, 1, 1, 8'hFF, 0);
            check("en0_Q", bus.Q, 8'h5A);
            check("en0_CNT", bus.CNT, 3);
        end
        for (int i = 0; i < 2; i++) begin
            step(1, 1, 2'b00, 1, 1, 8'hFF, 0);
            check("hold_Q", bus.Q, 8'h5A);
            check("hold_CNT", bus.CNT, 3);
        end

        // 5. reset in the middle of a shift sequence
        step(1, 1, 2'b11, 0, 0, 8'hFF, 0);
        for (int i = 0; i < 3; i++) step(1, 1, 2'b01, 1, 0, 8'h00, 0);
        check("mid_CNT", bus.CNT, 3);
        step(0, 1, 2'b01, 1, 1, 8'hFF, 0);
        check("midrst_Q", bus.Q, 8'h00);
        check("midrst_CNT", bus.CNT, 0);
        check("midrst_DONE", bus.DONE, 0);

`ifdef SHIFT_ROTATE_EN
        // 6. rotate
        step(1, 1, 2'b11, 0, 0, 8'h81, 1);
        step(1, 1, 2'b01, 0, 0, 8'h00, 1);
        check("rol_Q", bus.Q, 8'h03);
        step(1, 1, 2'b11, 0, 0, 8'h81, 1);
        step(1, 1, 2'b10, 0, 0, 8'h00, 1);
        check("ror_Q", bus.Q, 8'hC0);
        step(1, 1, 2'b11, 0, 0, 8'h81, 1);
        for (int i = 0; i < 8; i++) step(1, 1, 2'b01, 0, 0, 8'h00, 1);
        check("rol8_Q", bus.Q, 8'h81);
        check("rol8_DONE", bus.DONE, 1);
`endif

        // Randomized traffic; per-cycle compare checks against the model.
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 19) != 0),
                 ($urandom_range(0, 4) != 0),
                 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)),
                 8'($urandom_range(0, 255)),
                 1'($urandom_range(0, 1)));
        end

        @(negedge C);
        #1;
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/univ_shift_reg.md
Name: univ_shift_reg

Overview:
Parametrised universal shift register, the successor to the fixed 8-bit left-only shifter. It supports hold, shift-left, shift-right and parallel load, selected per cycle. A saturating shift counter and a DONE flag let a controller serialise or deserialise a full WIDTH-bit word without an external counter. It is used as a generic serialiser/deserialiser datapath element.

Parameters:
WIDTH, 8, register width in bits; legal values are WIDTH >= 2.
RST_VAL, 0, value loaded into Q on reset; WIDTH bits.

Ports:
C  in  1  clock; all state updates on the rising edge.
CLR  in  1  reset; synchronous, active-low.
EN  in  1  clock enable; when low, all state holds.
MODE  in  2  operation select: 00 hold, 01 shift left, 10 shift right, 11 parallel load.
SIL  in  1  serial input for shift-left; enters Q[0].
SIR  in  1  serial input for shift-right; enters Q[WIDTH-1].
D  in  WIDTH  parallel load data.
Q  out  WIDTH  register contents.
SOL  out  1  serial output for left shift; equals Q[WIDTH-1] (combinational from Q).
SOR  out  1  serial output for right shift; equals Q[0] (combinational from Q).
CNT  out  $clog2(WIDTH+1)  number of shifts since the last load or reset; saturates at WIDTH.
DONE  out  1  high when CNT == WIDTH (combinational from CNT).

Behaviour:
- Priority at each rising edge of C: CLR low, then EN low, then MODE.
- CLR low: Q=RST_VAL, CNT=0, so DONE=0. EN and MODE are ignored.
- Reset values: Q=RST_VAL, SOL=RST_VAL[WIDTH-1], SOR=RST_VAL[0], CNT=0, DONE=0.
- EN low: Q and CNT hold.
- MODE 00 (hold): Q and CNT hold.
- MODE 01 (shift left): Q <= {Q[WIDTH-2:0], SIL}; CNT <= min(CNT+1, WIDTH).
- MODE 10 (shift right): Q <= {SIR, Q[WIDTH-1:1]}; CNT <= min(CNT+1, WIDTH).
- MODE 11 (parallel load): Q <= D; CNT <= 0.
- Latency: one clock for every operation. Q, CNT and DONE reflect the edge immediately after the inputs are sampled.
- Saturation: shifts continue after CNT reaches WIDTH. Q keeps shifting, CNT stays at WIDTH, and DONE stays high until the next load or reset.
- Mixed directions: left and right shifts share one counter; each shift adds 1 regardless of direction.
- Reset mid-operation: CLR low during any mode aborts it at that edge; no partial result is retained.
- SOL/SOR always mirror the current Q. The bit shifted out on an edge is the SOL/SOR value present before that edge.
- No X propagation from unused inputs: SIR is ignored in mode 01, SIL in mode 10, and D in modes 00/01/10.

Optional Feature:
Macro SHIFT_ROTATE_EN.
- Defined: adds input port ROT (in, 1). When ROT=1:
  - mode 01 rotates left, Q <= {Q[WIDTH-2:0], Q[WIDTH-1]};
  - mode 10 rotates right, Q <= {Q[0], Q[WIDTH-1:1]};
  - SIL/SIR are ignored and CNT increments as for a shift.
- When ROT=0, behaviour is identical to the macro being undefined.
- Undefined: no ROT port; modes 01/10 always take SIL/SIR.

Test Plan:
1. Reset (WIDTH=8, RST_VAL=0): CLR=0 for 2 edges with EN=1, MODE=11, D=8'hA5 -> Q=8'h00, CNT=0, DONE=0.
2. Left serialise: load 8'hA5, then 8 edges of MODE=01, SIL=0.
   - Q goes 4A, 94, 28, 50, A0, 40, 80, 00.
   - SOL before each edge is 1,0,1,0,0,1,0,1.
   - CNT goes 1..8; DONE=1 after the 8th edge.
   - A 9th shift keeps CNT=8 and DONE=1.
3. Right deserialise: load 8'h00, then 8 edges of MODE=10, SIR=1 -> Q goes 80, C0, E0, F0, F8, FC, FE, FF; CNT=8, DONE=1. A following load of 8'h3C gives Q=3C, CNT=0, DONE=0.
4. Enable/hold: with Q=8'h5A, CNT=3, apply EN=0 with MODE=01 for 4 edges, then EN=1 with MODE=00 for 2 edges -> Q stays 5A and CNT stays 3 throughout.
5. Reset mid-shift: load 8'hFF, shift left 3 times with SIL=1, then CLR=0 with EN=1, MODE=01 -> next edge gives Q=00, CNT=0, DONE=0.
6. SHIFT_ROTATE_EN defined, ROT=1:
   - load 8'h81, then MODE=01 -> Q=8'h03;
   - reload 8'h81, then MODE=10 -> Q=8'hC0;
   - 8 consecutive left rotates from 8'h81 -> Q=8'h81, DONE=1.
